// File: rtl/timer_arbiter.sv
// timer_arbiter: four requesters share one interval timer; a round-robin FSM
// lends it to one owner at a time and reports expiry, cancellation and bad codes.

module timer_arbiter_slot (
  input  logic       Pclk,
  input  logic       Reset,
  input  logic       req_valid,
  input  logic [2:0] req_code,
  input  logic       cancel,
  input  logic       clr,
  output logic       pending,
  output logic [2:0] code,
  output logic       err
);
  logic illegal;

  assign illegal = (req_code[2:1] == 2'b11);

  // Cancel beats a same-cycle request; a repeat request while pending is dropped silently.
  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      pending <= 1'b0;
      code    <= 3'd0;
      err     <= 1'b0;
    end else begin
      err <= req_valid & ~cancel & ~pending & illegal;
      if (cancel | clr)
        pending <= 1'b0;
      else if (req_valid & ~pending & ~illegal) begin
        pending <= 1'b1;
        code    <= req_code;
      end
    end
  end
endmodule

module timer_arbiter (
  input  logic        Pclk,
  input  logic        Reset,
  input  logic [3:0]  ReqValid,
  input  logic [11:0] ReqCode,
  input  logic [3:0]  Cancel,
  output logic [3:0]  Grant,
  output logic [3:0]  Done,
  output logic [3:0]  Err,
  output logic        Busy,
  output logic        TmrStart,
  output logic        TmrEnable,
  output logic [2:0]  TmrCode,
  input  logic        TmrTimeOut
);
  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                   state;
  logic [1:0]               ptr, owner, sel;
  logic                     found, own_cancel;
  logic [NUM_REQ-1:0]       pending, avail, clr;
  logic [NUM_REQ-1:0][2:0]  codes;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_slot
      timer_arbiter_slot u_slot (
        .Pclk      (Pclk),
        .Reset     (Reset),
        .req_valid (ReqValid[g]),
        .req_code  (ReqCode[3*g +: 3]),
        .cancel    (Cancel[g]),
        .clr       (clr[g]),
        .pending   (pending[g]),
        .code      (codes[g]),
        .err       (Err[g])
      );
    end
  endgenerate

  // First set bit at or above base, wrapping; MSB of the result flags a hit.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = base + 2'(k);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // A requester cancelling in the selection cycle is not eligible.
  assign avail      = pending & ~Cancel;
  assign own_cancel = Cancel[owner];
  assign {found, sel} = rr_pick(avail, ptr);

  always_comb begin
    clr = '0;
    if (state == RUN && TmrTimeOut && !own_cancel)
      clr = 4'b0001 << owner;
  end

  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      owner     <= 2'd0;
      Grant     <= 4'b0000;
      Done      <= 4'b0000;
      Busy      <= 1'b0;
      TmrStart  <= 1'b0;
      TmrEnable <= 1'b0;
      TmrCode   <= 3'd0;
    end else begin
      Done     <= 4'b0000;
      TmrStart <= 1'b0;
      case (state)
        IDLE: if (found) begin
          state    <= LOAD;
          owner    <= sel;
          Grant    <= 4'b0001 << sel;
          TmrStart <= 1'b1;
          TmrCode  <= codes[sel];
          Busy     <= 1'b1;
        end
        LOAD, RUN: begin
          if (own_cancel) begin
            state     <= IDLE;
            Grant     <= 4'b0000;
            TmrEnable <= 1'b0;
            Busy      <= 1'b0;
            ptr       <= owner + 2'd1;
          end else if (state == LOAD) begin
            state     <= RUN;
            TmrEnable <= 1'b1;
          end else if (TmrTimeOut) begin
            state     <= DONE;
            Done      <= Grant;
            Grant     <= 4'b0000;
            TmrEnable <= 1'b0;
            ptr       <= owner + 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: vector table, directed corner sequences and a
// randomized run against a schedule-based reference model.
module tb_timer_arbiter;
  logic        Pclk = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  ReqValid = 4'b0, Cancel = 4'b0;
  logic [11:0] ReqCode = 12'b0;
  logic [3:0]  Grant, Done, Err;
  logic        Busy, TmrStart, TmrEnable;
  logic [2:0]  TmrCode;
  logic        TmrTimeOut;

  // Timer stand-in: interval for code c is 12*c ticks; manual override for collisions.
  logic        use_man = 1'b0, tmo_man = 1'b0;
  logic [7:0]  tick = 8'd0;

  int checks = 0, passes = 0, code_bad = 0, multi_grant = 0;

  always #5 Pclk = ~Pclk;

  always @(posedge Pclk) begin
    if (TmrStart) tick <= 8'd0;
    else if (TmrEnable && tick != 8'hFF) tick <= tick + 8'd1;
  end

  assign TmrTimeOut = use_man ? tmo_man : (int'(tick) >= 12 * int'(TmrCode));

  always @(negedge Pclk) begin
    if (TmrCode > 3'd5) code_bad++;
    if ((Grant & (Grant - 4'd1)) != 4'd0) multi_grant++;
  end

  timer_arbiter dut (
    .Pclk(Pclk), .Reset(Reset), .ReqValid(ReqValid), .ReqCode(ReqCode), .Cancel(Cancel),
    .Grant(Grant), .Done(Done), .Err(Err), .Busy(Busy), .TmrStart(TmrStart),
    .TmrEnable(TmrEnable), .TmrCode(TmrCode), .TmrTimeOut(TmrTimeOut)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge Pclk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0; ReqValid = 4'b0; Cancel = 4'b0; tmo_man = 1'b0;
    step(); step();
    Reset = 1'b1;
  endtask

  function automatic logic [11:0] pk(input int c3, input int c2, input int c1, input int c0);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  function automatic logic [31:0] outs();
    return {14'd0, Grant, Done, Err, Busy, TmrStart, TmrEnable, TmrCode};
  endfunction

  function automatic int idx_of(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 7;
    endcase
  endfunction

  typedef struct {
    logic [3:0]  rv;
    logic [11:0] code;
    logic [3:0]  cn;
    logic [3:0]  e_err;
    logic [3:0]  e_grant;
    logic [2:0]  e_tcode;
  } vec_t;

  vec_t vecs[9];

  // Reference model: owner plus phase counter since its grant cycle.
  logic [3:0] m_pend, m_err;
  int m_code[4];
  int m_ptr, m_own, m_ph, m_iv, m_tcode;

  task automatic model_reset();
    m_pend = 4'b0; m_err = 4'b0; m_ptr = 0; m_own = -1; m_ph = 0; m_iv = 0; m_tcode = 0;
    for (int i = 0; i < 4; i++) m_code[i] = 0;
  endtask

  task automatic model_step(input logic [3:0] rv, input logic [11:0] rc, input logic [3:0] cn);
    logic [3:0] clr;
    int c, j;
    clr = cn;
    for (int i = 0; i < 4; i++) begin
      c = int'(rc[3*i +: 3]);
      m_err[i] = rv[i] && !cn[i] && !m_pend[i] && c > 5;
    end
    if (m_own >= 0) begin
      if (m_ph <= m_iv + 1 && cn[m_own]) begin m_ptr = (m_own + 1) % 4; m_own = -1; end
      else if (m_ph == m_iv + 1) begin clr[m_own] = 1'b1; m_ptr = (m_own + 1) % 4; m_ph++; end
      else if (m_ph == m_iv + 2) m_own = -1;
      else m_ph++;
    end else begin
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (m_own < 0 && m_pend[j] && !cn[j]) begin
          m_own = j; m_ph = 0; m_iv = 12 * m_code[j]; m_tcode = m_code[j];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      c = int'(rc[3*i +: 3]);
      if (clr[i]) m_pend[i] = 1'b0;
      else if (rv[i] && !m_pend[i] && c <= 5) begin m_pend[i] = 1'b1; m_code[i] = c; end
    end
  endtask

  function automatic logic [31:0] model_outs();
    logic [3:0] g, d, oh;
    logic b, s, e;
    oh = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0;
    b  = (m_own >= 0);
    g  = (b && m_ph <= m_iv + 1) ? oh : 4'b0;
    d  = (b && m_ph == m_iv + 2) ? oh : 4'b0;
    s  = b && m_ph == 0;
    e  = b && m_ph >= 1 && m_ph <= m_iv + 1;
    return {14'd0, g, d, m_err, b, s, e, 3'(m_tcode)};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] ord;
    int nord, ndone, wide, dmis, d1, seen, bad;
    logic prev_start;
    logic [3:0] last_g, rv, cn;
    logic [11:0] rc;

    vecs[0] = '{4'b0100, pk(0,0,0,0), 4'b0000, 4'b0000, 4'b0100, 3'd0};
    vecs[1] = '{4'b1000, pk(7,0,0,0), 4'b0000, 4'b1000, 4'b0000, 3'd0};
    vecs[2] = '{4'b0001, pk(0,0,0,6), 4'b0000, 4'b0001, 4'b0000, 3'd0};
    vecs[3] = '{4'b0010, pk(0,0,5,0), 4'b0010, 4'b0000, 4'b0000, 3'd0};
    vecs[4] = '{4'b1000, pk(7,0,0,0), 4'b1000, 4'b0000, 4'b0000, 3'd0};
    vecs[5] = '{4'b1111, pk(1,2,3,4), 4'b0000, 4'b0000, 4'b0001, 3'd4};
    vecs[6] = '{4'b1010, pk(3,0,7,0), 4'b0000, 4'b0010, 4'b1000, 3'd3};
    vecs[7] = '{4'b0110, pk(0,6,2,0), 4'b0010, 4'b0100, 4'b0000, 3'd0};
    vecs[8] = '{4'b1100, pk(5,2,0,0), 4'b0100, 4'b0000, 4'b1000, 3'd5};

    // Reset state
    step(); step();
    check("reset_outs", outs(), 32'd0);
    Reset = 1'b1;

    // Single-cycle request table; timer held off so nothing completes
    use_man = 1'b1;
    foreach (vecs[i]) begin
      do_reset();
      ReqValid = vecs[i].rv; ReqCode = vecs[i].code; Cancel = vecs[i].cn;
      step();
      ReqValid = 4'b0; Cancel = 4'b0;
      check($sformatf("vec%0d_err", i), 32'(Err), 32'(vecs[i].e_err));
      check($sformatf("vec%0d_grant_early", i), 32'(Grant), 32'd0);
      step();
      check($sformatf("vec%0d_grant", i), 32'(Grant), 32'(vecs[i].e_grant));
      check($sformatf("vec%0d_tcode", i), 32'(TmrCode), 32'(vecs[i].e_tcode));
      check($sformatf("vec%0d_start", i), 32'(TmrStart), 32'(vecs[i].e_grant != 4'b0));
    end

    // Single request latency, code 000
    use_man = 1'b0;
    do_reset();
    ReqValid = 4'b0100; ReqCode = pk(0,0,0,0);
    step(); ReqValid = 4'b0;
    check("lat_c1_grant", 32'(Grant), 32'd0);
    check("lat_c1_busy", 32'(Busy), 32'd0);
    step();
    check("lat_c2", {29'd0, Grant[2], TmrStart, TmrEnable}, 32'b110);
    check("lat_c2_busy", 32'(Busy), 32'd1);
    step();
    check("lat_c3", {24'd0, Grant, 2'b0, TmrStart, TmrEnable}, {24'd0, 4'b0100, 4'b0001});
    step();
    check("lat_c4_done", 32'(Done), 32'h4);
    check("lat_c4_grant", 32'(Grant), 32'd0);
    step();
    check("lat_c5", {30'd0, Busy, Done != 4'b0}, 32'd0);

    // Round-robin over four simultaneous requests
    do_reset();
    ReqValid = 4'b1111; ReqCode = pk(0,0,0,0);
    step(); ReqValid = 4'b0;
    ord = 8'd0; nord = 0; ndone = 0; wide = 0; dmis = 0; prev_start = 1'b0; last_g = 4'b0;
    for (int c = 0; c < 60 && !(ndone == 4 && !Busy); c++) begin
      step();
      if (TmrStart) begin
        if (nord < 4) ord[2*nord +: 2] = 2'(idx_of(Grant));
        nord++;
      end
      if (prev_start && TmrStart) wide++;
      prev_start = TmrStart;
      if (Done != 4'b0) begin
        ndone++;
        if (Done != last_g) dmis++;
      end
      if (Grant != 4'b0) last_g = Grant;
    end
    check("rr_budget", 32'(ndone == 4 && !Busy), 32'd1);
    check("rr_order", 32'(ord), 32'hE4);
    check("rr_grants", 32'(nord), 32'd4);
    check("rr_done_count", 32'(ndone), 32'd4);
    check("rr_start_width", 32'(wide), 32'd0);
    check("rr_done_match", 32'(dmis), 32'd0);

    // Cancel owner ten cycles into RUN; others requested while busy
    do_reset();
    ReqValid = 4'b0010; ReqCode = pk(0,0,1,0);
    step(); ReqValid = 4'b0;
    d1 = 0;
    for (int c = 2; c <= 13; c++) begin
      step();
      ReqValid = (c == 5) ? 4'b0101 : 4'b0000;
      ReqCode  = pk(0,0,0,0);
      if (Done[1]) d1++;
    end
    check("cxl_pre_grant", 32'(Grant), 32'h2);
    check("cxl_pre_en", 32'(TmrEnable), 32'd1);
    Cancel = 4'b0010;
    step(); Cancel = 4'b0;
    if (Done[1]) d1++;
    check("cxl_grant", 32'(Grant), 32'd0);
    check("cxl_en", 32'(TmrEnable), 32'd0);
    check("cxl_busy", 32'(Busy), 32'd0);
    check("cxl_no_done", 32'(d1), 32'd0);
    step();
    check("cxl_next_from2", 32'(Grant), 32'h4);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      step();
      if (Grant == 4'b0001) seen = 1;
    end
    check("cxl_then_req0", 32'(seen), 32'd1);

    // Cancel and timeout collide in RUN; timeout ignored outside RUN
    use_man = 1'b1;
    do_reset();
    tmo_man = 1'b1;
    ReqValid = 4'b0001; ReqCode = pk(0,0,0,3);
    step(); ReqValid = 4'b0;
    step();
    check("col_load", {28'd0, Grant}, 32'h1);
    step(); tmo_man = 1'b0;
    check("col_run", {26'd0, Grant, TmrEnable, Done != 4'b0}, {26'd0, 4'b0001, 2'b10});
    step();
    tmo_man = 1'b1; Cancel = 4'b0001;
    step();
    tmo_man = 1'b0; Cancel = 4'b0;
    check("col_done", 32'(Done), 32'd0);
    check("col_state", {29'd0, Grant != 4'b0, Busy, TmrEnable}, 32'd0);
    step();
    check("col_idle", {30'd0, Grant != 4'b0, Busy}, 32'd0);

    // Reset during RUN with two pending requests
    use_man = 1'b0;
    do_reset();
    ReqValid = 4'b0011; ReqCode = pk(0,0,3,3);
    step(); ReqValid = 4'b0;
    repeat (5) step();
    check("rst_pre_run", {30'd0, Busy, TmrEnable}, 32'b11);
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    check("rst_outs", outs(), 32'd0);
    bad = 0;
    repeat (60) begin
      step();
      if (Grant != 4'b0 || Done != 4'b0) bad++;
    end
    check("rst_lost", 32'(bad), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        rv[i] = ($urandom_range(5) == 0);
        cn[i] = ($urandom_range(63) == 0);
      end
      rc = 12'($urandom);
      ReqValid = rv; ReqCode = rc; Cancel = cn;
      model_step(rv, rc, cn);
      step();
      check($sformatf("rand_c%0d", n), outs(), model_outs());
    end
    ReqValid = 4'b0; Cancel = 4'b0;

    check("tcode_legal", 32'(code_bad), 32'd0);
    check("grant_onehot", 32'(multi_grant), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
